// File: rtl/mac_ctrl_pkg.sv
// Shared types and default geometry for the systolic MAC array sequencer.
package mac_ctrl_pkg;

    localparam int unsigned DEF_ROWS    = 8;
    localparam int unsigned DEF_COLS    = 8;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned FIFO_RD_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } mac_ctrl_state_t;

endpackage

// File: rtl/skew_pipe.sv
// Shift register of the issued-read bit; tap i is the input delayed by i cycles.
module skew_pipe #(
    parameter int unsigned ROWS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_bit,
    output logic [ROWS-1:0] taps
);

    logic [ROWS-1:1] pipe_q;
    logic [ROWS-1:1] pipe_d;

    always_comb begin
        pipe_d = {pipe_q[ROWS-2:1], in_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Tap 0 is the live request so row 0 reads in the same cycle as B.
    assign taps = {pipe_q, in_bit};

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for the systolic MAC array: clears, streams B/A with per-row skew, drains, signals done.
// Optional B-stall counter enabled by defining MAC_CTRL_STALL_CNT_EN.
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
`ifdef MAC_CTRL_STALL_CNT_EN
    parameter int unsigned CNT_W = DEF_CNT_W,
`endif
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROWS-1:0]  rdempty_A,
    input  logic             rdempty_B,
    output logic [ROWS-1:0]  rdreq_A,
    output logic             rdreq_B,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             busy,
    output logic             done,
`ifdef MAC_CTRL_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic             underflow
);

    localparam int unsigned BCNT_W = $clog2(COLS + 1);
    localparam int unsigned DCNT_W = $clog2(ROWS + 1);

    mac_ctrl_state_t   state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [DCNT_W-1:0] drain_q, drain_d;
    logic              underflow_q, underflow_d;
    logic              mac_clr_q, mac_clr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              issue_c;
    logic [ROWS-1:0]   sched;
`ifdef MAC_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
`endif

    skew_pipe #(.ROWS(ROWS)) u_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_bit (issue_c),
        .taps   (sched)
    );

    // FIFO reads must see this cycle's empty flags, so requests are decoded from flops plus flags.
    assign issue_c = (state_q == ST_STREAM) && !rdempty_B;
    assign rdreq_B = issue_c;
    assign rdreq_A = sched & ~rdempty_A;
    assign mac_en  = sched[FIFO_RD_LAT];

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        drain_d     = drain_q;
        underflow_d = underflow_q | (|(sched & rdempty_A));
`ifdef MAC_CTRL_STALL_CNT_EN
        stall_cnt_d = stall_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                bcnt_d      = '0;
                drain_d     = '0;
                underflow_d = 1'b0;
`ifdef MAC_CTRL_STALL_CNT_EN
                stall_cnt_d = '0;
`endif
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (issue_c) bcnt_d = bcnt_q + BCNT_W'(1);
                if (bcnt_d == BCNT_W'(COLS)) state_d = ST_DRAIN;
`ifdef MAC_CTRL_STALL_CNT_EN
                if (rdempty_B && (stall_cnt_q != {CNT_W{1'b1}}))
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
`endif
            end
            ST_DRAIN: begin
                drain_d = drain_q + DCNT_W'(1);
                if (drain_q == DCNT_W'(ROWS)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mac_clr_d = (state_d == ST_CLEAR);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            drain_q     <= '0;
            underflow_q <= 1'b0;
            mac_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MAC_CTRL_STALL_CNT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            drain_q     <= drain_d;
            underflow_q <= underflow_d;
            mac_clr_q   <= mac_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MAC_CTRL_STALL_CNT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    assign mac_clr   = mac_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underflow = underflow_q;
`ifdef MAC_CTRL_STALL_CNT_EN
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: per-cycle expectations built from the run plan, compared as the DUT runs.
module tb_mac_array_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int NC   = 40;

    typedef struct packed {
        logic            b;
        logic [ROWS-1:0] a;
        logic            clr;
        logic            en;
        logic            bsy;
        logic            dn;
        logic            uf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [ROWS-1:0] rdempty_A;
    logic            rdempty_B;
    logic [ROWS-1:0] rdreq_A;
    logic            rdreq_B;
    logic            mac_clr;
    logic            mac_en;
    logic            busy;
    logic            done;
    logic            underflow;
`ifdef MAC_CTRL_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    int   n_total = 0;
    int   n_bad   = 0;
    int   cur_cyc = 0;
    logic prev_uf = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mac_array_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rdempty_A (rdempty_A),
        .rdempty_B (rdempty_B),
        .rdreq_A   (rdreq_A),
        .rdreq_B   (rdreq_B),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .busy      (busy),
        .done      (done),
`ifdef MAC_CTRL_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .underflow (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_cyc, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_rdreq_A"}, 32'(rdreq_A), 32'd0);
        chk({pfx, "_rdreq_B"}, 32'(rdreq_B), 32'd0);
        chk({pfx, "_mac_clr"}, 32'(mac_clr), 32'd0);
        chk({pfx, "_mac_en"}, 32'(mac_en), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_underflow"}, 32'(underflow), 32'd0);
`ifdef MAC_CTRL_STALL_CNT_EN
        chk({pfx, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    // One pass: B empty during [stall_lo,stall_hi], A FIFO 5 holds a5_depth entries,
    // optional extra start at start2, optional reset at rst_cyc.
    task automatic run(input int stall_lo, input int stall_hi, input int a5_depth,
                       input int start2, input int rst_cyc);
        logic            eb[0:NC-1];
        logic [ROWS-1:0] ea[0:NC-1];
        logic            euf[0:NC-1];
        int              dep[ROWS];
        int              used[ROWS];
        int              acnt[ROWS];
        int              bcnt;
        int              nb;
        int              last;
        int              d_cyc;
        int              nstall;
        logic            u;
        exp_t            e;

        for (int i = 0; i < ROWS; i++) begin
            dep[i]  = (i == 5) ? a5_depth : COLS;
            used[i] = 0;
        end
        nb   = 0;
        last = 0;
        for (int c = 0; c < NC; c++) begin
            eb[c] = 1'b0;
            if (c >= 2 && nb < COLS && !(c >= stall_lo && c <= stall_hi)) begin
                eb[c] = 1'b1;
                nb++;
                last = c;
            end
        end
        d_cyc  = last + 1 + (ROWS + 1);
        nstall = (stall_hi >= stall_lo) ? (stall_hi - stall_lo + 1) : 0;
        u = 1'b0;
        for (int c = 0; c < NC; c++) begin
            euf[c] = (c <= 1) ? prev_uf : u;
            ea[c]  = '0;
            for (int i = 0; i < ROWS; i++) begin
                if (c >= i && eb[c - i]) begin
                    if (used[i] < dep[i]) begin
                        ea[c][i] = 1'b1;
                        used[i]++;
                    end else begin
                        u = 1'b1;
                    end
                end
            end
        end
        for (int c = 0; c <= d_cyc + 3; c++) begin
            e.b   = eb[c];
            e.a   = ea[c];
            e.clr = (c == 1);
            e.en  = (c >= 1) ? eb[c - 1] : 1'b0;
            e.bsy = (c >= 1 && c <= d_cyc);
            e.dn  = (c == d_cyc);
            e.uf  = euf[c];
            exp_q.push_back(e);
        end

        bcnt = COLS;
        for (int i = 0; i < ROWS; i++) acnt[i] = dep[i];

        for (int c = 0; c <= d_cyc + 3; c++) begin
            @(negedge clk);
            cur_cyc   = c;
            start     = (c == 0) || (c == start2);
            rdempty_B = (bcnt == 0) || (c >= stall_lo && c <= stall_hi);
            for (int i = 0; i < ROWS; i++) rdempty_A[i] = (acnt[i] == 0);
            #1;
            e = exp_q.pop_front();
            chk("rdreq_B", 32'(rdreq_B), 32'(e.b));
            chk("rdreq_A", 32'(rdreq_A), 32'(e.a));
            chk("mac_clr", 32'(mac_clr), 32'(e.clr));
            chk("mac_en", 32'(mac_en), 32'(e.en));
            chk("busy", 32'(busy), 32'(e.bsy));
            chk("done", 32'(done), 32'(e.dn));
            chk("underflow", 32'(underflow), 32'(e.uf));
            if (rdreq_B && bcnt > 0) bcnt--;
            for (int i = 0; i < ROWS; i++)
                if (rdreq_A[i] && acnt[i] > 0) acnt[i]--;
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("midrst");
                exp_q.delete();
                prev_uf = 1'b0;
                start   = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        start = 1'b0;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef MAC_CTRL_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(nstall));
`else
        if (nstall < 0) chk("stall_plan", 32'(nstall), 32'd0);
`endif
        prev_uf = u;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        rdempty_A = '1;
        rdempty_B = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(99, 98, COLS, -1, -1);   // nominal
        run(4, 6, COLS, -1, -1);     // B stall mid-stream
        run(99, 98, 6, -1, -1);      // A FIFO 5 runs dry
        run(99, 98, COLS, 5, -1);    // start while busy, stale underflow visible until CLEAR
        run(99, 98, COLS, -1, 8);    // reset mid-run
        repeat (2) @(negedge clk);
        run(99, 98, COLS, -1, -1);   // clean run after reset

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cur_cyc);
        $fatal(1, "timeout");
    end

endmodule
